// File: rtl/cla_pkg.sv
// Shared definitions for the serial carry-lookahead adder: group count,
// nibble-index width and FSM state encoding.
package cla_pkg;

    localparam int NIBBLES_DEF  = 8;
    localparam int NIBBLE_IDX_W = $clog2(NIBBLES_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cla_state_e;

endpackage

// File: rtl/cla_nibble_sum.sv
// Combinational 4-bit carry-lookahead group: sum bits, group generate and
// propagate, and the carry into bit 3 (needed for signed overflow on the top group).
module cla_nibble_sum (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       g_o,
    output logic       p_o,
    output logic       c3_o
);

    logic [3:0] g_s;
    logic [3:0] p_s;
    logic [3:0] c_s;

    assign g_s = a_i & b_i;
    assign p_s = a_i | b_i;

    // Carries are expanded from the group carry-in so no ripple path exists inside the group.
    assign c_s[0] = cin_i;
    assign c_s[1] = g_s[0] | (p_s[0] & cin_i);
    assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin_i);
    assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                  | (p_s[2] & p_s[1] & p_s[0] & cin_i);

    assign sum_o = a_i ^ b_i ^ c_s;
    assign g_o   = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                 | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);
    assign p_o   = &p_s;
    assign c3_o  = c_s[3];

endmodule

// File: rtl/serial_cla_adder32.sv
// Serial adder/subtractor: one 4-bit lookahead group per clock, result,
// carry-out and signed overflow presented after the last group.
module serial_cla_adder32
    import cla_pkg::*;
#(
    parameter int NIBBLES = NIBBLES_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   sub,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic                   overflow
);

    localparam int W = 4 * NIBBLES;
    localparam logic [NIBBLE_IDX_W-1:0] LAST_IDX = NIBBLE_IDX_W'(NIBBLES - 1);

    cla_state_e              state_q, state_d;
    logic [W-1:0]            a_q, a_d;
    logic [W-1:0]            b_q, b_d;
    logic                    carry_q, carry_d;
    logic [NIBBLE_IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]            result_q, result_d;
    logic                    cout_q, cout_d;
    logic                    ovf_q, ovf_d;

    logic [3:0] nib_a_s;
    logic [3:0] nib_b_s;
    logic [3:0] nib_sum_s;
    logic       nib_g_s;
    logic       nib_p_s;
    logic       nib_c3_s;
    logic       grp_carry_s;

    assign nib_a_s     = a_q[{idx_q, 2'b00} +: 4];
    assign nib_b_s     = b_q[{idx_q, 2'b00} +: 4];
    assign grp_carry_s = nib_g_s | (nib_p_s & carry_q);

    cla_nibble_sum u_nibble (
        .a_i   (nib_a_s),
        .b_i   (nib_b_s),
        .cin_i (carry_q),
        .sum_o (nib_sum_s),
        .g_o   (nib_g_s),
        .p_o   (nib_p_s),
        .c3_o  (nib_c3_s)
    );

    // State and datapath registers; any reset discards an in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= {W{1'b0}};
            b_q      <= {W{1'b0}};
            carry_q  <= 1'b0;
            idx_q    <= {NIBBLE_IDX_W{1'b0}};
            result_q <= {W{1'b0}};
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    // Next-state and datapath update; subtraction is a + ~b + 1 via the initial carry.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b ^ {W{sub}};
                    carry_d  = sub;
                    idx_d    = {NIBBLE_IDX_W{1'b0}};
                    result_d = {W{1'b0}};
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                result_d[{idx_q, 2'b00} +: 4] = nib_sum_s;
                carry_d = grp_carry_s;
                if (idx_q == LAST_IDX) begin
                    cout_d  = grp_carry_s;
                    ovf_d   = nib_c3_s ^ grp_carry_s;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + NIBBLE_IDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_cla_adder32.sv
// Randomized and directed bench for serial_cla_adder32 against an arithmetic reference model.
module tb_serial_cla_adder32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        cout;
    logic        overflow;

    int total;
    int bad;

    serial_cla_adder32 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Reference: {overflow, cout, result} from plain integer arithmetic.
    function automatic logic [33:0] ref_op(input logic [31:0] x, input logic [31:0] y, input logic s);
        longint      sx, sy, sr;
        logic [32:0] t;
        logic [31:0] r;
        logic        c, o;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sr = s ? (sx - sy) : (sx + sy);
        o  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        t  = {1'b0, x} + {1'b0, y};
        c  = s ? (x >= y) : t[32];
        r  = s ? (x - y) : (x + y);
        return {o, c, r};
    endfunction

    // Start one operation and count edges until done (bounded; 20 means timeout).
    task automatic launch(input logic [31:0] x, input logic [31:0] y, input logic s, output int lat);
        @(negedge clk);
        a = x; b = y; sub = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        int lat;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = 32'h0; b = 32'h0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, cout, overflow, result} !== 36'h0) begin
            bad++;
            $display("FAIL reset_state: got busy=%b done=%b cout=%b ovf=%b result=%h, want all 0",
                     busy, done, cout, overflow, result);
        end
        // Start presented on the very first edge after reset release.
        rst_n = 1'b1; a = 32'd1; b = 32'd2; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat !== 8 || result !== 32'd3) begin
            bad++;
            $display("FAIL first_edge_start: got lat=%0d result=%h, want lat=8 result=00000003", lat, result);
        end
    endtask

    task automatic test_directed();
        logic [31:0] va [5] = '{32'h0000_0005, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0003};
        logic [31:0] vb [5] = '{32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0005};
        logic        vs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [33:0] ve [5] = '{{2'b00, 32'h0000_0008}, {2'b01, 32'h0000_0000}, {2'b10, 32'h8000_0000},
                                {2'b11, 32'h7FFF_FFFF}, {2'b00, 32'hFFFF_FFFE}};
        int lat;
        for (int i = 0; i < 5; i++) begin
            launch(va[i], vb[i], vs[i], lat);
            total++;
            if ({overflow, cout, result} !== ve[i] || lat !== 8) begin
                bad++;
                $display("FAIL directed_%0d: got ovf=%b cout=%b result=%h lat=%0d, want ovf=%b cout=%b result=%h lat=8",
                         i, overflow, cout, result, lat, ve[i][33], ve[i][32], ve[i][31:0]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] x, y;
        logic        s;
        logic [33:0] exp;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            x = $urandom;
            y = (i % 5 == 0) ? x : $urandom;
            s = 1'($urandom_range(0, 1));
            exp = ref_op(x, y, s);
            launch(x, y, s, lat);
            total++;
            if ({overflow, cout, result} !== exp || lat !== 8) begin
                bad++;
                $display("FAIL random_%0d: a=%h b=%h sub=%b got ovf=%b cout=%b result=%h lat=%0d, want ovf=%b cout=%b result=%h lat=8",
                         i, x, y, s, overflow, cout, result, lat, exp[33], exp[32], exp[31:0]);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [31:0] x, y;
        logic [33:0] exp;
        int          lat;
        x = $urandom; y = $urandom;
        exp = ref_op(x, y, 1'b1);
        @(negedge clk);
        a = x; b = y; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_in_run: got %b, want 1", busy);
        end
        a = ~x; b = x ^ y; sub = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 4) start = 1'b0;
        end
        total++;
        if ({overflow, cout, result} !== exp || lat !== 8) begin
            bad++;
            $display("FAIL ignore_start: got ovf=%b cout=%b result=%h lat=%0d, want ovf=%b cout=%b result=%h lat=8",
                     overflow, cout, result, lat, exp[33], exp[32], exp[31:0]);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || {overflow, cout, result} !== exp) begin
            bad++;
            $display("FAIL hold_after_done: got done=%b busy=%b result=%h, want done=0 busy=0 result=%h",
                     done, busy, result, exp[31:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] xs [4];
        logic [31:0] ys [4];
        logic        ss [4];
        logic [33:0] exp;
        int          cyc, last, k;
        for (int i = 0; i < 4; i++) begin
            xs[i] = $urandom; ys[i] = $urandom; ss[i] = 1'(i % 2);
        end
        @(negedge clk);
        a = xs[0]; b = ys[0]; sub = ss[0]; start = 1'b1;
        cyc = 0; last = 0; k = 0;
        while (k < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                exp = ref_op(xs[k], ys[k], ss[k]);
                total++;
                if ({overflow, cout, result} !== exp || (cyc - last) !== 9) begin
                    bad++;
                    $display("FAIL back_to_back_%0d: got result=%h ovf=%b cout=%b gap=%0d, want result=%h ovf=%b cout=%b gap=9",
                             k, result, overflow, cout, cyc - last, exp[31:0], exp[33], exp[32]);
                end
                last = cyc;
                k++;
                if (k < 4) begin
                    a = xs[k]; b = ys[k]; sub = ss[k];
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        total++;
        if (k !== 4) begin
            bad++;
            $display("FAIL back_to_back_count: got %0d completions, want 4", k);
        end
    endtask

    task automatic test_mid_reset();
        int lat;
        @(negedge clk);
        a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, cout, overflow, result} !== 36'h0) begin
            bad++;
            $display("FAIL mid_reset_async: got busy=%b done=%b cout=%b ovf=%b result=%h, want all 0",
                     busy, done, cout, overflow, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            bad++;
            $display("FAIL mid_reset_idle: got busy=%b done=%b result=%h, want 0 0 00000000", busy, done, result);
        end
        launch(32'd10, 32'd20, 1'b0, lat);
        total++;
        if (result !== 32'd30 || lat !== 8) begin
            bad++;
            $display("FAIL after_reset_op: got result=%h lat=%0d, want 0000001e lat=8", result, lat);
        end
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = 32'h0; b = 32'h0;
        total = 0; bad = 0;
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
